// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and
// registers the returned word into the IF/ID pipeline register. Handles
// stall, redirect/flush, halt on ECALL/EBREAK and PC range/alignment faults.
// Optional build macro FETCH_CNT_EN adds a 32-bit valid-fetch counter output
// fetch_cnt_o.
module fetch_stage #(
  parameter int unsigned ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_data_i,
  output logic [31:0]       ifid_pc_o,
  output logic [31:0]       ifid_pc4_o,
  output logic [31:0]       ifid_inst_o,
  output logic              ifid_valid_o,
  output logic              halted_o,
  output logic              fault_o
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0]       fetch_cnt_o
`endif
);

  localparam int unsigned HI_LSB = ADDR_W + 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_FAULT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc4;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        w_capture;
  logic        w_tgt_bad;
  logic        w_pc4_bad;
  logic        w_is_sys;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_ifid_inst;

  assign w_pc4       = r_pc + 32'd4;
  assign w_tgt_bad   = (redirect_pc_i[1:0] != 2'b00) || (redirect_pc_i[31:HI_LSB] != '0);
  assign w_pc4_bad   = (w_pc4[31:HI_LSB] != '0);
  assign w_is_sys    = (imem_data_i == ECALL) || (imem_data_i == EBREAK);

  assign imem_addr_o  = r_pc[ADDR_W+1:2];
  assign ifid_pc_o    = r_ifid_pc;
  assign ifid_pc4_o   = r_ifid_pc4;
  assign ifid_inst_o  = r_ifid_inst;
  assign ifid_valid_o = r_valid;
  assign halted_o     = (r_state == S_HALT);
  assign fault_o      = (r_state == S_FAULT);

  // Next-state, next-PC and IF/ID capture decision; priority redirect > stall > fetch
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_capture   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (redirect_i) begin
          w_valid_nxt = 1'b0;
          if (w_tgt_bad) w_state_nxt = S_FAULT;
          else           w_pc_nxt    = redirect_pc_i;
        end else if (!stall_i) begin
          w_capture   = 1'b1;
          w_valid_nxt = 1'b1;
          if (w_is_sys)       w_state_nxt = S_HALT;
          else if (w_pc4_bad) w_state_nxt = S_FAULT;
          else                w_pc_nxt    = w_pc4;
        end
      end
      S_HALT: begin
        w_valid_nxt = 1'b0;
        if (redirect_i) begin
          if (w_tgt_bad) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_state_nxt = S_RUN;
            w_pc_nxt    = redirect_pc_i;
          end
        end
      end
      S_FAULT: begin
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_FAULT;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, PC and valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // IF/ID payload: loaded only on a real fetch, otherwise held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifid_pc   <= '0;
      r_ifid_pc4  <= '0;
      r_ifid_inst <= NOP;
    end else if (w_capture) begin
      r_ifid_pc   <= r_pc;
      r_ifid_pc4  <= w_pc4;
      r_ifid_inst <= imem_data_i;
    end
  end

`ifdef FETCH_CNT_EN
  logic [31:0] r_fetch_cnt;

  // Count edges that load a valid instruction into IF/ID
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_fetch_cnt <= '0;
    else if (w_capture) r_fetch_cnt <= r_fetch_cnt + 32'd1;
  end

  assign fetch_cnt_o = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stimulus against a transaction-level model of the fetch rules.
module tb_fetch_stage;

  localparam int unsigned MEM_WORDS = 64;
  localparam int unsigned MEM_BYTES = 4 * MEM_WORDS;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [5:0]  imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
  logic [31:0] ifid_inst_o;
  logic        ifid_valid_o;
  logic        halted_o;
  logic        fault_o;
`ifdef FETCH_CNT_EN
  logic [31:0] fetch_cnt_o;
`endif

  logic [31:0] mem [0:MEM_WORDS-1];
  assign imem_data_i = mem[imem_addr_o];

  int n_pass = 0;
  int n_total = 0;

  // model state: mode 0=run 1=halt 2=fault
  logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, m_cnt;
  logic        m_valid;
  int          m_mode;

  fetch_stage #(.ADDR_W(6), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_pc4_o    (ifid_pc4_o),
    .ifid_inst_o   (ifid_inst_o),
    .ifid_valid_o  (ifid_valid_o),
    .halted_o      (halted_o),
    .fault_o       (fault_o)
`ifdef FETCH_CNT_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_inst = 32'h13;
    m_valid = 1'b0; m_mode = 0; m_cnt = 32'h0;
  endtask

  // One clock edge of fetch behaviour, described in architectural terms
  task automatic model_edge(input bit st, input bit rd, input logic [31:0] tgt);
    logic [31:0] w;
    if (m_mode == 2) begin
      m_valid = 1'b0;
    end else if (rd) begin
      m_valid = 1'b0;
      if ((tgt % 4) != 0 || tgt >= MEM_BYTES) m_mode = 2;
      else begin m_pc = tgt; m_mode = 0; end
    end else if (m_mode == 1) begin
      m_valid = 1'b0;
    end else if (!st) begin
      w = mem[m_pc / 4];
      m_ipc = m_pc; m_ipc4 = m_pc + 4; m_inst = w; m_valid = 1'b1; m_cnt = m_cnt + 1;
      if (w == 32'h73 || w == 32'h0010_0073) m_mode = 1;
      else if (m_pc + 4 >= MEM_BYTES) m_mode = 2;
      else m_pc = m_pc + 4;
    end
  endtask

  task automatic tick(input bit st, input bit rd, input logic [31:0] tgt);
    stall_i = st; redirect_i = rd; redirect_pc_i = tgt;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic load_program();
    for (int unsigned i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0000_0013;
    mem[0] = 32'h0010_0093; mem[1] = 32'h0020_81b3; mem[2] = 32'h0000_0013; mem[3] = 32'h0000_0073;
  endtask

  task automatic test_reset();
    load_program();
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    n_total++; if (ifid_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", ifid_valid_o); else n_pass++;
    n_total++; if (ifid_pc_o !== 32'h0) $display("FAIL reset_ifid_pc got=%h exp=0", ifid_pc_o); else n_pass++;
    n_total++; if (ifid_pc4_o !== 32'h0) $display("FAIL reset_ifid_pc4 got=%h exp=0", ifid_pc4_o); else n_pass++;
    n_total++; if (ifid_inst_o !== 32'h13) $display("FAIL reset_inst got=%h exp=00000013", ifid_inst_o); else n_pass++;
    n_total++; if (imem_addr_o !== 6'd0) $display("FAIL reset_addr got=%0d exp=0", imem_addr_o); else n_pass++;
    n_total++; if (halted_o !== 1'b0 || fault_o !== 1'b0) $display("FAIL reset_flags got=%b%b exp=00", halted_o, fault_o); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_fetch_stall();
    tick(0, 0, 0);
    n_total++; if (ifid_pc_o !== 32'h0 || ifid_valid_o !== 1'b1) $display("FAIL fetch1 got pc=%h v=%b exp pc=0 v=1", ifid_pc_o, ifid_valid_o); else n_pass++;
    n_total++; if (ifid_inst_o !== 32'h0010_0093 || imem_addr_o !== 6'd1) $display("FAIL fetch1_inst got=%h a=%0d exp=00100093 a=1", ifid_inst_o, imem_addr_o); else n_pass++;
    tick(0, 0, 0);
    n_total++; if (ifid_pc_o !== 32'h4 || ifid_pc4_o !== 32'h8) $display("FAIL fetch2 got pc=%h pc4=%h exp 4/8", ifid_pc_o, ifid_pc4_o); else n_pass++;
    n_total++; if (imem_addr_o !== 6'd2 || ifid_inst_o !== 32'h0020_81b3) $display("FAIL fetch2_inst got a=%0d i=%h exp a=2 i=002081b3", imem_addr_o, ifid_inst_o); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0);
      n_total++; if (imem_addr_o !== 6'd2 || ifid_pc_o !== 32'h4 || ifid_valid_o !== 1'b1) $display("FAIL stall%0d got a=%0d pc=%h v=%b exp a=2 pc=4 v=1", i, imem_addr_o, ifid_pc_o, ifid_valid_o); else n_pass++;
    end
    tick(0, 0, 0);
    n_total++; if (ifid_pc_o !== 32'h8 || imem_addr_o !== 6'd3) $display("FAIL resume got pc=%h a=%0d exp pc=8 a=3", ifid_pc_o, imem_addr_o); else n_pass++;
  endtask

  task automatic test_halt();
    tick(0, 0, 0);
    n_total++; if (ifid_inst_o !== 32'h73 || halted_o !== 1'b1 || ifid_valid_o !== 1'b1) $display("FAIL halt_enter got i=%h h=%b v=%b exp 73/1/1", ifid_inst_o, halted_o, ifid_valid_o); else n_pass++;
    n_total++; if (ifid_pc_o !== 32'hc || imem_addr_o !== 6'd3) $display("FAIL halt_pc got pc=%h a=%0d exp c/3", ifid_pc_o, imem_addr_o); else n_pass++;
    tick(1, 0, 0);
    n_total++; if (ifid_valid_o !== 1'b0 || halted_o !== 1'b1 || imem_addr_o !== 6'd3) $display("FAIL halt_hold got v=%b h=%b a=%0d exp 0/1/3", ifid_valid_o, halted_o, imem_addr_o); else n_pass++;
    tick(0, 0, 0);
    n_total++; if (ifid_valid_o !== 1'b0 || halted_o !== 1'b1 || imem_addr_o !== 6'd3) $display("FAIL halt_stay got v=%b h=%b a=%0d exp 0/1/3", ifid_valid_o, halted_o, imem_addr_o); else n_pass++;
  endtask

  task automatic test_redirect();
    tick(1, 1, 32'h10);
    n_total++; if (halted_o !== 1'b0 || ifid_valid_o !== 1'b0 || imem_addr_o !== 6'd4) $display("FAIL redir_halt got h=%b v=%b a=%0d exp 0/0/4", halted_o, ifid_valid_o, imem_addr_o); else n_pass++;
    n_total++; if (ifid_pc_o !== 32'hc) $display("FAIL redir_keep_pc got=%h exp=c", ifid_pc_o); else n_pass++;
    tick(0, 0, 0);
    n_total++; if (ifid_pc_o !== 32'h10 || ifid_valid_o !== 1'b1 || imem_addr_o !== 6'd5) $display("FAIL redir_fetch got pc=%h v=%b a=%0d exp 10/1/5", ifid_pc_o, ifid_valid_o, imem_addr_o); else n_pass++;
    tick(1, 1, 32'h0);
    n_total++; if (ifid_valid_o !== 1'b0 || imem_addr_o !== 6'd0 || ifid_pc_o !== 32'h10) $display("FAIL redir_stall got v=%b a=%0d pc=%h exp 0/0/10", ifid_valid_o, imem_addr_o, ifid_pc_o); else n_pass++;
    tick(0, 0, 0);
    n_total++; if (ifid_pc_o !== 32'h0 || ifid_valid_o !== 1'b1) $display("FAIL redir_restart got pc=%h v=%b exp 0/1", ifid_pc_o, ifid_valid_o); else n_pass++;
  endtask

  task automatic test_fault();
    do_reset();
    tick(0, 1, 32'h6);
    n_total++; if (fault_o !== 1'b1 || ifid_valid_o !== 1'b0 || imem_addr_o !== 6'd0) $display("FAIL fault_misalign got f=%b v=%b a=%0d exp 1/0/0", fault_o, ifid_valid_o, imem_addr_o); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick(1'($urandom), 1'($urandom), 32'h20);
      n_total++; if (fault_o !== 1'b1 || ifid_valid_o !== 1'b0 || imem_addr_o !== 6'd0 || ifid_pc_o !== 32'h0 || ifid_inst_o !== 32'h13)
        $display("FAIL fault_sticky%0d got f=%b v=%b a=%0d pc=%h i=%h exp 1/0/0/0/13", i, fault_o, ifid_valid_o, imem_addr_o, ifid_pc_o, ifid_inst_o); else n_pass++;
    end
    do_reset();
    tick(0, 1, 32'h100);
    n_total++; if (fault_o !== 1'b1 || ifid_valid_o !== 1'b0) $display("FAIL fault_range got f=%b v=%b exp 1/0", fault_o, ifid_valid_o); else n_pass++;
    do_reset();
    tick(0, 1, 32'd252);
    n_total++; if (fault_o !== 1'b0 || imem_addr_o !== 6'd63) $display("FAIL top_redirect got f=%b a=%0d exp 0/63", fault_o, imem_addr_o); else n_pass++;
    tick(0, 0, 0);
    n_total++; if (ifid_pc_o !== 32'd252 || ifid_pc4_o !== 32'd256 || ifid_valid_o !== 1'b1 || fault_o !== 1'b1 || imem_addr_o !== 6'd63)
      $display("FAIL top_word got pc=%h pc4=%h v=%b f=%b a=%0d exp fc/100/1/1/63", ifid_pc_o, ifid_pc4_o, ifid_valid_o, fault_o, imem_addr_o); else n_pass++;
    tick(0, 0, 0);
    n_total++; if (ifid_valid_o !== 1'b0 || fault_o !== 1'b1 || imem_addr_o !== 6'd63) $display("FAIL top_after got v=%b f=%b a=%0d exp 0/1/63", ifid_valid_o, fault_o, imem_addr_o); else n_pass++;
  endtask

`ifdef FETCH_CNT_EN
  task automatic test_count();
    load_program();
    mem[3] = 32'h0000_0013;
    do_reset();
    for (int i = 0; i < 5; i++) tick(0, 0, 0);
    tick(1, 0, 0); tick(1, 0, 0);
    tick(0, 1, 32'h0);
    n_total++; if (fetch_cnt_o !== 32'd5) $display("FAIL count got=%0d exp=5", fetch_cnt_o); else n_pass++;
    tick(0, 0, 0);
    rst = 1'b1; #1;
    n_total++; if (fetch_cnt_o !== 32'd0) $display("FAIL count_rst got=%0d exp=0", fetch_cnt_o); else n_pass++;
    rst = 1'b0;
  endtask
`endif

  task automatic test_random();
    bit st, rd;
    logic [31:0] tgt;
    logic [5:0]  e_addr;
    for (int unsigned i = 0; i < MEM_WORDS; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 19) == 0) mem[i] = ($urandom_range(0, 1) == 0) ? 32'h0000_0073 : 32'h0010_0073;
    end
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0 || (m_mode == 2 && $urandom_range(0, 7) == 0)) begin
        rst = 1'b1; #1;
        model_reset();
        n_total++; if (ifid_valid_o !== 1'b0 || imem_addr_o !== 6'd0 || fault_o !== 1'b0 || halted_o !== 1'b0)
          $display("FAIL rnd_async_rst c=%0d got v=%b a=%0d f=%b h=%b exp 0/0/0/0", c, ifid_valid_o, imem_addr_o, fault_o, halted_o); else n_pass++;
        rst = 1'b0;
      end
      st = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 9) == 0);
      tgt = ($urandom_range(0, 4) != 0) ? {24'h0, 6'($urandom_range(0, 63)), 2'b00} : $urandom;
      model_edge(st, rd, tgt);
      tick(st, rd, tgt);
      e_addr = 6'((m_pc / 4) % MEM_WORDS);
      n_total++; if (imem_addr_o !== e_addr) $display("FAIL rnd_addr c=%0d got=%0d exp=%0d", c, imem_addr_o, e_addr); else n_pass++;
      n_total++; if (ifid_valid_o !== m_valid) $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, ifid_valid_o, m_valid); else n_pass++;
      n_total++; if (ifid_pc_o !== m_ipc || ifid_pc4_o !== m_ipc4) $display("FAIL rnd_pc c=%0d got=%h/%h exp=%h/%h", c, ifid_pc_o, ifid_pc4_o, m_ipc, m_ipc4); else n_pass++;
      n_total++; if (ifid_inst_o !== m_inst) $display("FAIL rnd_inst c=%0d got=%h exp=%h", c, ifid_inst_o, m_inst); else n_pass++;
      n_total++; if (halted_o !== (m_mode == 1) || fault_o !== (m_mode == 2)) $display("FAIL rnd_flags c=%0d got h=%b f=%b exp mode=%0d", c, halted_o, fault_o, m_mode); else n_pass++;
`ifdef FETCH_CNT_EN
      n_total++; if (fetch_cnt_o !== m_cnt) $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, fetch_cnt_o, m_cnt); else n_pass++;
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fetch_stall();
    test_halt();
    test_redirect();
    test_fault();
`ifdef FETCH_CNT_EN
    test_count();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
